// File: rtl/led_matrix_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : led_matrix_pkg
//  Purpose  : Shared types, sizes and helpers for the 8x8 LED matrix scanner.
//  Revision : 1.0 - initial release
// ============================================================================
package led_matrix_pkg;

  localparam int ROWS    = 8;
  localparam int COLS    = 8;
  localparam int SR_BITS = 16;

  // Scanner sequencing states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    LATCH = 3'd3,
    HOLD  = 3'd4
  } state_t;

  // Row-select byte: bit idx set, all others clear
  function automatic logic [7:0] onehot8(input logic [2:0] idx);
    return 8'd1 << idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sr_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : sr_serializer
//  Purpose  : Shifts a 16-bit word MSB first into a 74HC595-style chain.
//             Each bit holds sr_clk low for CLK_DIV cycles, then high for
//             CLK_DIV cycles; done is asserted on the final cycle of the
//             last bit so the caller can leave its shift state on time.
//  Revision : 1.0 - initial release
// ============================================================================
module sr_serializer
  import led_matrix_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] word,
  output logic        sr_data,
  output logic        sr_clk,
  output logic        done
);

  localparam int c_PH_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [15:0]       r_shift;
  logic              r_busy;
  logic [c_PH_W-1:0] r_phase;
  logic              r_high;
  logic [3:0]        r_bit;
  logic              r_sr_data;
  logic              r_sr_clk;
  logic              w_phase_end;

  assign w_phase_end = (r_phase == c_PH_W'(CLK_DIV - 1));
  assign done        = r_busy && w_phase_end && r_high && (r_bit == 4'(SR_BITS - 1));
  assign sr_data     = r_sr_data;
  assign sr_clk      = r_sr_clk;

  // Bit/phase sequencer: counters clear on start and only run while busy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift   <= '0;
      r_busy    <= 1'b0;
      r_phase   <= '0;
      r_high    <= 1'b0;
      r_bit     <= '0;
      r_sr_data <= 1'b0;
      r_sr_clk  <= 1'b0;
    end else if (start) begin
      r_shift   <= {word[14:0], 1'b0};
      r_sr_data <= word[15];
      r_sr_clk  <= 1'b0;
      r_phase   <= '0;
      r_high    <= 1'b0;
      r_bit     <= '0;
      r_busy    <= 1'b1;
    end else if (r_busy) begin
      if (w_phase_end) begin
        r_phase <= '0;
        if (!r_high) begin
          r_high   <= 1'b1;
          r_sr_clk <= 1'b1;
        end else begin
          r_high   <= 1'b0;
          r_sr_clk <= 1'b0;
          if (r_bit == 4'(SR_BITS - 1)) begin
            r_busy    <= 1'b0;
            r_sr_data <= 1'b0;
          end else begin
            r_bit     <= r_bit + 4'd1;
            r_sr_data <= r_shift[15];
            r_shift   <= {r_shift[14:0], 1'b0};
          end
        end
      end else begin
        r_phase <= r_phase + c_PH_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/led_matrix_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : led_matrix_scanner
//  Purpose  : Double-buffers the 64-bit game frame and row-scans an 8x8 LED
//             matrix through a serial shift-register chain.
//             Optional DIM_EN: PWM the output enable during HOLD from the
//             3-bit brightness input (sampled in LOAD).
//  Revision : 1.0 - initial release
// ============================================================================
module led_matrix_scanner
  import led_matrix_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int ROW_HOLD = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [63:0] frame_in,
  input  logic        frame_valid,
  input  logic [2:0]  brightness,
  output logic        sr_data,
  output logic        sr_clk,
  output logic        sr_latch,
  output logic        sr_oe_n,
  output logic [2:0]  row_idx,
  output logic        frame_done
);

  localparam int c_HOLD_W = $clog2(ROW_HOLD);

  state_t              r_state;
  logic [63:0]         r_frame_buf;
  logic [2:0]          r_row;
  logic [c_HOLD_W-1:0] r_hold;
  logic                r_latch;
  logic                r_oe_n;
  logic                r_done;
  logic [63:0]         w_src;
  logic [COLS-1:0]     w_row_bits;
  logic [15:0]         w_word;
  logic                w_start;
  logic                w_sr_done;
  logic                w_hold_last;

`ifdef DIM_EN
  logic [c_HOLD_W:0]   r_dim_limit;
`else
  logic                w_unused_brightness;
  assign w_unused_brightness = ^brightness;
`endif

  // A new frame is only taken at row 0, so a scan never mixes two frames
  assign w_src       = (r_row == 3'd0 && frame_valid) ? frame_in : r_frame_buf;
  assign w_row_bits  = w_src[{r_row, 3'b000} +: COLS];
  assign w_word      = {onehot8(r_row), w_row_bits};
  assign w_start     = (r_state == LOAD);
  assign w_hold_last = (r_hold == c_HOLD_W'(ROW_HOLD - 1));

  assign sr_latch   = r_latch;
  assign sr_oe_n    = r_oe_n;
  assign row_idx    = r_row;
  assign frame_done = r_done;

  sr_serializer #(
    .CLK_DIV (CLK_DIV)
  ) u_ser (
    .clk     (clk),
    .rst     (rst),
    .start   (w_start),
    .word    (w_word),
    .sr_data (sr_data),
    .sr_clk  (sr_clk),
    .done    (w_sr_done)
  );

  // Row-scan sequencer with registered latch/enable/row/frame-done outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_frame_buf <= '0;
      r_row       <= '0;
      r_hold      <= '0;
      r_latch     <= 1'b0;
      r_oe_n      <= 1'b1;
      r_done      <= 1'b0;
`ifdef DIM_EN
      r_dim_limit <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_oe_n  <= 1'b1;
          r_latch <= 1'b0;
          r_done  <= 1'b0;
          r_row   <= '0;
          if (enable) r_state <= LOAD;
        end
        LOAD: begin
          if (r_row == 3'd0 && frame_valid) r_frame_buf <= frame_in;
`ifdef DIM_EN
          r_dim_limit <= (c_HOLD_W+1)'(((32'(brightness) + 32'd1) * 32'(ROW_HOLD)) >> 3);
`endif
          r_state <= SHIFT;
        end
        SHIFT: begin
          // Previous row stays lit until the new one is latched
          if (w_sr_done) begin
            r_latch <= 1'b1;
            r_oe_n  <= 1'b1;
            r_state <= LATCH;
          end
        end
        LATCH: begin
          r_latch <= 1'b0;
          r_oe_n  <= 1'b0;
          r_hold  <= '0;
          r_state <= HOLD;
        end
        HOLD: begin
          if (w_hold_last) begin
            r_done <= 1'b0;
            r_row  <= r_row + 3'd1;
            if (enable) begin
              r_state <= LOAD;
            end else begin
              r_oe_n  <= 1'b1;
              r_state <= IDLE;
            end
          end else begin
            r_hold <= r_hold + c_HOLD_W'(1);
            // Registered one cycle early so the pulse lands on the last HOLD cycle
            r_done <= (r_row == 3'd7) && (r_hold == c_HOLD_W'(ROW_HOLD - 2));
`ifdef DIM_EN
            r_oe_n <= (({1'b0, r_hold} + (c_HOLD_W+1)'(1)) >= r_dim_limit);
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
